uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal range is 4 and above.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range is 5-9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning 1 or 2 stop bits checked.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; must be a power of 2 and at least 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rd_data, output, DATA_BITS: head FIFO entry.
REQ-010 SHALL have port rd_valid, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port rd_ready, input, 1 bit: consumer accepts head.
REQ-012 SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 SHALL have port parity_err, output, 1 bit: sticky parity-error flag.
REQ-014 SHALL have port frame_err, output, 1 bit: sticky framing-error flag.
REQ-015 SHALL have port overrun_err, output, 1 bit: sticky FIFO-overrun flag.
REQ-016 SHALL have port err_clr, input, 1 bit: clears all sticky flags.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value rx_s.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-019 IDLE: a 1-to-0 transition of rx_s SHALL move to START and clear the bit-timer.
REQ-020 START: at timer = CLKS_PER_BIT/2-1 (mid-bit), rx_s=0 SHALL move to DATA with timer reset; rx_s=1 is a false start and SHALL return to IDLE with no flag.
REQ-021 DATA: rx_s SHALL be sampled every CLKS_PER_BIT cycles from the START mid-point, LSB first, for DATA_BITS samples, then move to PARITY if PARITY!=0, else to STOP.
REQ-022 PARITY: one sample SHALL be taken; a mismatch against even/odd parity of the data marks the frame bad-parity.
REQ-023 STOP: STOP_BITS samples SHALL be taken, each of which must be 1; any 0 marks the frame bad-frame.
REQ-024 After the last stop sample, a good frame SHALL return to IDLE, and a bad-frame SHALL enter BREAK, which leaves to IDLE only once rx_s=1.
REQ-025 A good frame SHALL be written to the FIFO in the cycle after the last stop sample; rd_valid SHALL rise the following cycle if the FIFO was empty.
REQ-026 A bad-parity frame SHALL be discarded and set parity_err; a bad-frame frame SHALL be discarded and set frame_err (frame error takes priority; only frame_err set).
REQ-027 A pop SHALL occur when rd_valid && rd_ready at the clock edge; rd_data is valid combinationally from the head while rd_valid=1.
REQ-028 A push when count=FIFO_DEPTH with no simultaneous pop SHALL drop the byte and set overrun_err; push and pop in the same cycle while full SHALL both succeed with count unchanged.
REQ-029 Push and pop in the same cycle while empty SHALL push only; the new byte becomes visible the next cycle.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-031 err_clr SHALL clear all three flags next cycle; a set event in the same cycle as err_clr SHALL win (flag stays 1).
REQ-032 The 9th data bit (DATA_BITS=9) SHALL be stored as rd_data[8]; unused width SHALL not exist.

Reset
REQ-033 rst_n=0 SHALL immediately force FSM=IDLE, FIFO empty, count=0, rd_valid=0, rd_data=0, all error flags=0, synchronizer=1, timers=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release, no byte SHALL be produced until a fresh start edge arrives.

Verification
REQ-035 Defaults, frame 0xA5 at 16 clk/bit -> rd_data=0xA5, rd_valid=1 between 153 and 156 cycles after the rx falling edge, no flags.
REQ-036 PARITY=1: send 0x03 with parity bit 1 -> no push, parity_err=1; with parity bit 0 -> 0x03 received.
REQ-037 Stop bit driven 0 for 0x55 -> no push, frame_err=1, FSM stays in BREAK until rx high; following 0x12 received correctly.
REQ-038 rd_ready=0, send FIFO_DEPTH+1 bytes 0x00..0x08 -> count=8, overrun_err=1, drained order 0x00..0x07.
REQ-039 rx low pulse of 4 cycles -> false start, no push, no flags; err_clr with simultaneous overrun -> overrun_err remains 1.
REQ-040 rst_n pulsed low during DATA of 0x7E -> all outputs 0, no byte delivered; next frame 0x81 received intact.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receiver (configurable data/parity/stop bits) with an
//                oversampled bit timer, sticky error flags and a power-of-2
//                receive FIFO with a valid/ready read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = 4;

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_prev;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bad;
  logic                  stop_bad;
  logic                  push_req;
  logic                  perr_evt;
  logic                  ferr_evt;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  logic                  exp_par;
  logic                  stop_now_bad;
  logic                  full;
  logic                  pop;
  logic                  do_push;
  logic                  overrun_evt;

  // Expected parity bit over the assembled data word (even or odd)
  assign exp_par      = (PARITY == 2) ? ~(^shreg) : (^shreg);
  // A frame is bad if any stop sample so far, including this one, was low
  assign stop_now_bad = stop_bad | ~rx_s;

  // Two-flop synchronizer plus one delayed copy for start-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receive FSM: bit timing, sampling, frame checking and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
      push_req <= 1'b0;
      perr_evt <= 1'b0;
      ferr_evt <= 1'b0;
    end else begin
      push_req <= 1'b0;
      perr_evt <= 1'b0;
      ferr_evt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= ST_START;
            timer <= '0;
          end
        end
        ST_START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (!rx_s) begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              par_bad  <= 1'b0;
              stop_bad <= 1'b0;
            end else begin
              // Glitch shorter than half a bit: not a real start bit
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_PARITY: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            par_bad <= (rx_s != exp_par);
            state   <= ST_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (timer == BIT_LAST) begin
            timer    <= '0;
            stop_bad <= stop_now_bad;
            if (stop_idx == STOP_LAST) begin
              if (stop_now_bad) begin
                // Framing error wins over parity error
                state    <= ST_BREAK;
                ferr_evt <= 1'b1;
              end else begin
                state <= ST_IDLE;
                if (par_bad) begin
                  perr_evt <= 1'b1;
                end else begin
                  push_req <= 1'b1;
                end
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_BREAK: begin
          // Wait for the line to return high before hunting a new start
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_valid    = (count != '0);
  assign full        = (count == DEPTH_C);
  assign pop         = rd_valid & rd_ready;
  assign do_push     = push_req & (~full | pop);
  assign overrun_evt = push_req & full & ~pop;
  assign rd_data     = rd_valid ? mem[rd_ptr] : '0;

  // FIFO storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set event in the clear cycle keeps the flag high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= perr_evt    | (parity_err  & ~err_clr);
      frame_err   <= ferr_evt    | (frame_err   & ~err_clr);
      overrun_err <= overrun_evt | (overrun_err & ~err_clr);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo (no-parity and
//                even-parity instances), table vectors plus corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1;
  logic       rd_ready0, rd_ready1;
  logic       err_clr0, err_clr1;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic [3:0] count0, count1;
  logic       perr0, ferr0, oerr0;
  logic       perr1, ferr1, oerr1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
    .count(count0), .parity_err(perr0), .frame_err(ferr0),
    .overrun_err(oerr0), .err_clr(err_clr0)
  );

  uart_rx_fifo #(.PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready1),
    .count(count1), .parity_err(perr1), .frame_err(ferr1),
    .overrun_err(oerr1), .err_clr(err_clr1)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       exp_push;
    logic       exp_perr;
  } pvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Serialize one frame LSB first; extra_low holds the line low after the stop bit
  task automatic drive_frame(input int which, input logic [7:0] d, input logic has_par,
                             input logic par_bit, input logic stop_bit, input int extra_low);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    n = 9;
    if (has_par) begin
      bits[9] = par_bit;
      n = 10;
    end
    bits[n] = stop_bit;
    n = n + 1;
    for (int i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      cyc(CPB);
    end
    if (extra_low > 0) begin
      set_rx(which, 1'b0);
      cyc(extra_low);
    end
    set_rx(which, 1'b1);
  endtask

  task automatic pop0();
    rd_ready0 = 1'b1;
    cyc(1);
    rd_ready0 = 1'b0;
  endtask

  task automatic pop1();
    rd_ready1 = 1'b1;
    cyc(1);
    rd_ready1 = 1'b0;
  endtask

  task automatic clr0();
    err_clr0 = 1'b1;
    cyc(1);
    err_clr0 = 1'b0;
  endtask

  task automatic clr1();
    err_clr1 = 1'b1;
    cyc(1);
    err_clr1 = 1'b0;
  endtask

  initial begin
    vec_t       vecs [8];
    pvec_t      pvecs[4];
    logic [7:0] drain[8];
    int         lat;
    int         seen;
    logic [7:0] got;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h12, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h7E, 1'b1, 1'b1, 1'b0};

    pvecs[0] = '{8'h03, 1'b1, 1'b0, 1'b1};
    pvecs[1] = '{8'h03, 1'b0, 1'b1, 1'b0};
    pvecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0};
    pvecs[3] = '{8'h07, 1'b0, 1'b0, 1'b1};

    drain[0] = 8'h02; drain[1] = 8'h03; drain[2] = 8'h04; drain[3] = 8'h05;
    drain[4] = 8'h06; drain[5] = 8'h07; drain[6] = 8'h09; drain[7] = 8'h0A;

    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    rd_ready0 = 1'b0; rd_ready1 = 1'b0; err_clr0 = 1'b0; err_clr1 = 1'b0;
    #1;
    check("reset_count", count0, 0);
    check("reset_valid", rd_valid0, 0);
    check("reset_data", rd_data0, 0);
    check("reset_flags", {perr0, ferr0, oerr0}, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    // Latency of a single default frame, measured from the rx falling edge
    lat = 0;
    fork
      drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 0);
      begin
        while (!rd_valid0 && lat < 400) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    check("latency_153_156", (lat >= 153 && lat <= 156), 1);
    check("lat_data", rd_data0, 8'hA5);
    check("lat_flags", {perr0, ferr0, oerr0}, 0);
    pop0();
    cyc(2 * CPB);

    // Table-driven frames on the no-parity instance
    for (int i = 0; i < 8; i++) begin
      clr0();
      drive_frame(0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop_bit, 0);
      cyc(2 * CPB);
      check($sformatf("vec%0d_count", i), count0, vecs[i].exp_push ? 1 : 0);
      check($sformatf("vec%0d_data", i), rd_data0, vecs[i].exp_push ? vecs[i].data : 8'h00);
      check($sformatf("vec%0d_ferr", i), ferr0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_perr", i), perr0, 0);
      pop0();
      check($sformatf("vec%0d_empty", i), count0, 0);
    end

    // Bad stop followed by a long low line, then a clean frame
    clr0();
    drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 3 * CPB);
    cyc(2 * CPB);
    check("break_count", count0, 0);
    check("break_ferr", ferr0, 1);
    drive_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 0);
    cyc(2 * CPB);
    check("after_break_count", count0, 1);
    check("after_break_data", rd_data0, 8'h12);
    check("after_break_ferr_sticky", ferr0, 1);
    pop0();
    clr0();
    check("ferr_cleared", ferr0, 0);

    // Even-parity instance
    for (int i = 0; i < 4; i++) begin
      clr1();
      drive_frame(1, pvecs[i].data, 1'b1, pvecs[i].par_bit, 1'b1, 0);
      cyc(2 * CPB);
      check($sformatf("pvec%0d_count", i), count1, pvecs[i].exp_push ? 1 : 0);
      check($sformatf("pvec%0d_data", i), rd_data1, pvecs[i].exp_push ? pvecs[i].data : 8'h00);
      check($sformatf("pvec%0d_perr", i), perr1, pvecs[i].exp_perr);
      check($sformatf("pvec%0d_ferr", i), ferr1, 0);
      pop1();
    end

    // Fill the FIFO without reading
    for (int b = 0; b < DEPTH; b++) begin
      drive_frame(0, 8'(b), 1'b0, 1'b0, 1'b1, 0);
      cyc(CPB);
    end
    check("full_count", count0, DEPTH);
    check("full_no_overrun", oerr0, 0);

    // Ninth byte overflows while err_clr is held through the push edge
    fork
      drive_frame(0, 8'h08, 1'b0, 1'b0, 1'b1, 0);
      begin
        err_clr0 = 1'b1;
        repeat (lat) @(posedge clk);
        #1 err_clr0 = 1'b0;
      end
    join
    cyc(CPB);
    check("overrun_set_wins", oerr0, 1);
    check("overrun_count", count0, DEPTH);
    check("overrun_head", rd_data0, 8'h00);
    pop0();
    drive_frame(0, 8'h09, 1'b0, 1'b0, 1'b1, 0);
    cyc(CPB);
    check("refill_count", count0, DEPTH);
    clr0();
    check("overrun_cleared", oerr0, 0);

    // Push and pop on the same edge while full
    fork
      drive_frame(0, 8'h0A, 1'b0, 1'b0, 1'b1, 0);
      begin
        repeat (lat - 1) @(posedge clk);
        #1 rd_ready0 = 1'b1;
        @(posedge clk);
        #1 rd_ready0 = 1'b0;
      end
    join
    cyc(CPB);
    check("full_pushpop_count", count0, DEPTH);
    check("full_pushpop_no_overrun", oerr0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("drain%0d", k), rd_data0, drain[k]);
      pop0();
    end
    check("drained_count", count0, 0);
    check("drained_valid", rd_valid0, 0);

    // Push into an empty FIFO with rd_ready held high: visible one cycle
    seen = 0;
    got  = 8'h00;
    rd_ready0 = 1'b1;
    fork
      drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 0);
      begin
        for (int c = 0; c < 220; c++) begin
          @(posedge clk); #1;
          if (rd_valid0) begin
            seen++;
            got = rd_data0;
          end
        end
      end
    join
    rd_ready0 = 1'b0;
    check("empty_pushpop_seen", seen, 1);
    check("empty_pushpop_data", got, 8'h5A);
    check("empty_pushpop_count", count0, 0);

    // Short low glitch is a false start
    rx0 = 1'b0;
    cyc(4);
    rx0 = 1'b1;
    cyc(3 * CPB);
    check("false_start_count", count0, 0);
    check("false_start_flags", {perr0, ferr0, oerr0}, 0);

    // Reset in the middle of a frame, with prior state to wipe
    drive_frame(0, 8'h33, 1'b0, 1'b0, 1'b1, 0);
    cyc(CPB);
    drive_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 0);
    cyc(2 * CPB);
    check("pre_reset_count", count0, 1);
    check("pre_reset_ferr", ferr0, 1);
    rx0 = 1'b0; cyc(CPB);
    rx0 = 1'b0; cyc(CPB);
    rx0 = 1'b1; cyc(CPB);
    rx0 = 1'b1; cyc(7);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_count", count0, 0);
    check("midreset_valid", rd_valid0, 0);
    check("midreset_data", rd_data0, 0);
    check("midreset_flags", {perr0, ferr0, oerr0}, 0);
    cyc(3);
    rx0 = 1'b1;
    rst_n = 1'b1;
    cyc(4 * CPB);
    check("post_reset_no_byte", count0, 0);
    drive_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 0);
    cyc(2 * CPB);
    check("post_reset_count", count0, 1);
    check("post_reset_data", rd_data0, 8'h81);
    check("post_reset_flags", {perr0, ferr0, oerr0}, 0);
    pop0();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
